calc_op_sequencer: RTL and testbench
====================================

CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 SHALL have the following ports, clock and reset first:
  clk  in  1  sole clock; all state updates on the rising edge.
  reset  in  1  synchronous, active-high reset.
  start  in  1  request to begin one operation; sampled only in IDLE.
  Add_Sub  in  1  requested operation: 0 = A+B, 1 = A-B.
  A_sign  in  1  sign of operand A (1 = negative).
  A_mag  in  8  magnitude of operand A.
  B_sign  in  1  sign of operand B (1 = negative).
  B_mag  in  8  magnitude of operand B.
  result_ack  in  1  consumer acknowledge of a presented result.
  ready  out  1  high exactly when in IDLE.
  result_valid  out  1  high exactly when in DONE.
  sign  out  1  sign of the result.
  magnitude  out  9  result magnitude; bit 8 is the carry.
  op_count  out  8  count of completed (acknowledged) operations.

Function
REQ-002 SHALL implement the states IDLE, COMPARE, EXECUTE, CORRECT and DONE.
REQ-003 SHALL, in IDLE with start=1 at an edge, latch A_sign, A_mag, B_sign, B_mag and Add_Sub, then move to COMPARE.
REQ-004 SHALL ignore start and all operand inputs in every state except IDLE, so latched operands stay stable for the whole operation.
REQ-005 SHALL, in COMPARE, register eop = Add_Sub XOR A_sign XOR B_sign and ALB = (A_mag < B_mag), then move to EXECUTE unconditionally.
REQ-006 SHALL, in EXECUTE, register the raw 8-bit sum and the carry C_8:
  - eop=0: A_mag + B_mag.
  - eop=1: A_mag + ~B_mag + 1 (two's-complement difference).
  Then move to CORRECT.
REQ-007 SHALL, in CORRECT, form and register the final result, then move to DONE:
  - magnitude[8] = C_8 when eop=0; 0 when eop=1.
  - magnitude[7:0] = raw sum, except when eop=1 and ALB=1, where it is the two's complement (negation) of the raw sum.
REQ-008 SHALL compute sign as follows:
  - A_sign when eop=0, or when eop=1 and ALB=0.
  - B_sign XOR Add_Sub when eop=1 and ALB=1.
  - Forced to 0 whenever magnitude = 0 (no negative zero).
REQ-009 SHALL assert result_valid 4 edges after the edge that accepted start.
REQ-010 SHALL hold sign and magnitude constant while in DONE.
REQ-011 SHALL, in DONE with result_ack=1 at an edge, return to IDLE, deassert result_valid and increment op_count by 1, wrapping 255 -> 0.
REQ-012 SHALL remain in DONE indefinitely while result_ack=0.
REQ-013 SHALL ignore result_ack outside DONE.
REQ-014 SHALL NOT accept a new operation on the same edge that leaves DONE; start is accepted no earlier than the following edge (minimum 5 edges per operation).
REQ-015 SHALL keep sign and magnitude holding the last completed result while in IDLE, COMPARE, EXECUTE and CORRECT.

Reset
REQ-016 SHALL, on any edge with reset=1, force these values regardless of state, including mid-operation and in DONE:
  - state = IDLE, ready = 1, result_valid = 0.
  - sign = 0, magnitude = 0, op_count = 0.
  - latched operands and intermediates = 0.
REQ-017 SHALL give reset priority over start and result_ack on the same edge.
REQ-018 SHALL accept start on the first edge after reset is deasserted.

Verification
REQ-019 Add, same signs: A=+100, B=+200, Add_Sub=0 -> after 4 edges result_valid=1, sign=0, magnitude=300 (0x12C).
REQ-020 Subtract, borrow case: A=+5, B=+9, Add_Sub=1 -> sign=1, magnitude=4.
REQ-021 Mixed signs, zero result: A=-7, B=+7, Add_Sub=0 -> sign=0, magnitude=0.
REQ-022 Stall and counter wrap: hold result_ack=0 for 10 cycles -> result_valid and outputs stable throughout; 256 acknowledged operations -> op_count wraps to 0.
REQ-023 Reset mid-operation: reset=1 in EXECUTE -> next edge ready=1, result_valid=0, magnitude=0, op_count=0; a new start then yields a correct result.
REQ-024 Busy protocol: start pulsed in COMPARE with different operands -> ignored; the result reflects the originally latched operands, and ready stays 0 until after the acknowledge.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Multi-cycle sign-magnitude adder/subtractor. One operation walks through
// IDLE -> COMPARE -> EXECUTE -> CORRECT -> DONE and then waits in DONE until the
// consumer acknowledges the result.
//
// Handshake: start is taken only while ready=1 (IDLE). A result is offered while
// result_valid=1 (DONE) and is consumed on the first rising edge at which
// result_ack=1; ready returns on that same edge, but a new start is sampled no
// earlier than the following edge.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   start        begin one operation (sampled in IDLE only)
//   Add_Sub      0 = A+B, 1 = A-B
//   A_sign/A_mag operand A, sign-magnitude (sign 1 = negative)
//   B_sign/B_mag operand B, sign-magnitude
//   result_ack   consumer acknowledge (acted on in DONE only)
//   ready        high in IDLE
//   result_valid high in DONE
//   sign         result sign (never negative zero)
//   magnitude    9-bit result magnitude, bit 8 is the carry
//   op_count     number of acknowledged operations, wraps at 256
module calc_op_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       Add_Sub,
    input  logic       A_sign,
    input  logic [7:0] A_mag,
    input  logic       B_sign,
    input  logic [7:0] B_mag,
    input  logic       result_ack,
    output logic       ready,
    output logic       result_valid,
    output logic       sign,
    output logic [8:0] magnitude,
    output logic [7:0] op_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        EXECUTE = 3'd2,
        CORRECT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request
    logic       add_sub_q;
    logic       a_sign_q;
    logic [7:0] a_mag_q;
    logic       b_sign_q;
    logic [7:0] b_mag_q;

    // Intermediates
    logic       eop;      // effective operation: 1 = magnitudes subtract
    logic       alb;      // |A| < |B|
    logic [7:0] raw_sum;
    logic       c8;

    // Final result formed from the intermediates
    logic [7:0] mag_lo;
    logic [8:0] mag_next;
    logic       sign_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. DONE returns to IDLE rather than straight to
    // COMPARE, so a start held across the acknowledge edge is not taken
    // until the edge after it.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COMPARE;
            COMPARE: state_next = EXECUTE;
            EXECUTE: state_next = CORRECT;
            CORRECT: state_next = DONE;
            DONE:    if (result_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready        = (state == IDLE);
    assign result_valid = (state == DONE);

    // ------------------------------------------------------------------
    // Correction step. When the magnitudes were subtracted and |A| < |B|,
    // the raw sum is the negative of |B|-|A| and has to be negated back;
    // the result then carries B's effective sign (B_sign flipped for a
    // subtract). A zero result always reads as positive.
    // ------------------------------------------------------------------
    always_comb begin
        mag_lo    = (eop && alb) ? (~raw_sum + 8'd1) : raw_sum;
        mag_next  = {(eop ? 1'b0 : c8), mag_lo};
        sign_next = (eop && alb) ? (b_sign_q ^ add_sub_q) : a_sign_q;
        if (mag_next == 9'd0) begin
            sign_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath. Each register only loads in its own state, so operands
    // stay frozen once accepted and the outputs keep the last completed
    // result until the next CORRECT step overwrites them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            add_sub_q <= 1'b0;
            a_sign_q  <= 1'b0;
            a_mag_q   <= 8'd0;
            b_sign_q  <= 1'b0;
            b_mag_q   <= 8'd0;
            eop       <= 1'b0;
            alb       <= 1'b0;
            raw_sum   <= 8'd0;
            c8        <= 1'b0;
            sign      <= 1'b0;
            magnitude <= 9'd0;
            op_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        add_sub_q <= Add_Sub;
                        a_sign_q  <= A_sign;
                        a_mag_q   <= A_mag;
                        b_sign_q  <= B_sign;
                        b_mag_q   <= B_mag;
                    end
                end
                COMPARE: begin
                    eop <= add_sub_q ^ a_sign_q ^ b_sign_q;
                    alb <= (a_mag_q < b_mag_q);
                end
                EXECUTE: begin
                    // Subtraction is A + ~B + 1; the +1 enters as eop itself.
                    {c8, raw_sum} <= {1'b0, a_mag_q}
                                   + {1'b0, (eop ? ~b_mag_q : b_mag_q)}
                                   + {8'd0, eop};
                end
                CORRECT: begin
                    sign      <= sign_next;
                    magnitude <= mag_next;
                end
                DONE: begin
                    if (result_ack) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed cases plus randomized operations,
// checked by a scoreboard whose expected results come from signed-integer
// arithmetic on the operands.
module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       add_sub;
    logic       a_sign;
    logic [7:0] a_mag;
    logic       b_sign;
    logic [7:0] b_mag;
    logic       result_ack;
    logic       ready;
    logic       result_valid;
    logic       sign;
    logic [8:0] magnitude;
    logic [7:0] op_count;

    calc_op_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .Add_Sub      (add_sub),
        .A_sign       (a_sign),
        .A_mag        (a_mag),
        .B_sign       (b_sign),
        .B_mag        (b_mag),
        .result_ack   (result_ack),
        .ready        (ready),
        .result_valid (result_valid),
        .sign         (sign),
        .magnitude    (magnitude),
        .op_count     (op_count)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];     // {sign, magnitude}
    int         acc_q[$];     // cycle index of the accepting edge
    logic [7:0] exp_count;
    logic [9:0] last_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: interpret sign-magnitude operands as integers, add or
    // subtract, and re-encode the result as sign + absolute value.
    function automatic logic [9:0] model(input logic as, input logic [7:0] am,
                                         input logic bs, input logic [7:0] bm,
                                         input logic sub);
        int a, b, r;
        a = as ? -int'(am) : int'(am);
        b = bs ? -int'(bm) : int'(bm);
        r = sub ? (a - b) : (a + b);
        if (r < 0) return {1'b1, 9'(-r)};
        return {1'b0, 9'(r)};
    endfunction

    // ---------------- monitor ----------------
    logic       prev_v = 1'b0;
    logic [9:0] cur;
    int         acc;
    always @(negedge clk) begin
        if (!reset && result_valid) begin
            if (!prev_v) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=0x%0h required=none", {sign, magnitude});
                end else begin
                    cur = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check("latency_edges_incl_accept", cyc - acc + 1, 4);
                    check("result", {sign, magnitude}, cur);
                end
            end else begin
                check("hold_in_done", {sign, magnitude}, cur);
            end
        end
        prev_v = result_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        result_ack = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_valid", result_valid, 0);
        check("rst_sign", sign, 0);
        check("rst_magnitude", magnitude, 0);
        check("rst_op_count", op_count, 0);
        exp_q.delete();
        acc_q.delete();
        exp_count = 8'd0;
        last_res  = 10'd0;
        reset     = 1'b0;
    endtask

    task automatic run_op(input logic as, input logic [7:0] am, input logic bs,
                          input logic [7:0] bm, input logic sub, input int stall,
                          input bit busy_poke, input bit start_on_ack);
        int n;
        logic [9:0] e;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("wait_ready_timeout", ready, 1);
            return;
        end
        e       = model(as, am, bs, bm, sub);
        a_sign  = as;
        a_mag   = am;
        b_sign  = bs;
        b_mag   = bm;
        add_sub = sub;
        start   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        start = 1'b0;
        check("ready_low_busy", ready, 0);
        // Inputs change after acceptance; the result must not follow them.
        a_sign  = ~as;
        a_mag   = am + 8'd1;
        b_sign  = 1'($urandom_range(0, 1));
        b_mag   = bm ^ 8'h5a;
        add_sub = ~sub;
        if (busy_poke) begin
            start      = 1'b1;
            result_ack = 1'b1;
            @(posedge clk);
            #1;
            start      = 1'b0;
            result_ack = 1'b0;
            check("ready_low_after_poke", ready, 0);
        end
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!result_valid) begin
            check("wait_valid_timeout", result_valid, 1);
            return;
        end
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        check("valid_after_stall", result_valid, 1);
        result_ack = 1'b1;
        if (start_on_ack) start = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        exp_count  = exp_count + 8'd1;
        last_res   = e;
        check("ready_after_ack", ready, 1);
        check("valid_after_ack", result_valid, 0);
        check("op_count", op_count, exp_count);
        check("result_held_idle", {sign, magnitude}, last_res);
        if (start_on_ack) begin
            // Taken on this edge instead; complete it so the bench stays in step.
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_q.push_back(model(a_sign, a_mag, b_sign, b_mag, add_sub));
            acc_q.push_back(cyc);
            check("start_taken_next_edge", ready, 0);
            n = 0;
            while (!result_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("valid_second", result_valid, 1);
            last_res   = model(a_sign, a_mag, b_sign, b_mag, add_sub);
            result_ack = 1'b1;
            @(posedge clk);
            #1;
            result_ack = 1'b0;
            exp_count  = exp_count + 8'd1;
            check("op_count_second", op_count, exp_count);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; add_sub = 1'b0; a_sign = 1'b0; a_mag = 8'd0;
        b_sign = 1'b0; b_mag = 8'd0; result_ack = 1'b0;
        @(negedge clk);
        do_reset();

        run_op(1'b0, 8'd100, 1'b0, 8'd200, 1'b0, 0, 1'b0, 1'b0);  // +100 + +200 = 300
        run_op(1'b0, 8'd5,   1'b0, 8'd9,   1'b1, 10, 1'b0, 1'b0); // +5 - +9 = -4, stalled
        run_op(1'b1, 8'd7,   1'b0, 8'd7,   1'b0, 2, 1'b0, 1'b0);  // -7 + +7 = 0
        run_op(1'b1, 8'd255, 1'b1, 8'd255, 1'b0, 1, 1'b0, 1'b0);  // -510
        run_op(1'b1, 8'd5,   1'b1, 8'd5,   1'b1, 0, 1'b0, 1'b0);  // -5 - -5 = 0
        run_op(1'b1, 8'd0,   1'b0, 8'd0,   1'b1, 0, 1'b0, 1'b0);  // -0 - +0 = 0
        run_op(1'b0, 8'd30,  1'b1, 8'd40,  1'b0, 0, 1'b1, 1'b0);  // busy poke, -10
        run_op(1'b1, 8'd200, 1'b0, 8'd1,   1'b0, 0, 1'b0, 1'b1);  // start held on ack

        // Reset while in EXECUTE
        @(negedge clk);
        a_sign = 1'b0; a_mag = 8'd50; b_sign = 1'b0; b_mag = 8'd60; add_sub = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        do_reset();
        run_op(1'b0, 8'd17, 1'b1, 8'd3, 1'b1, 0, 1'b0, 1'b0);     // +17 - -3 = 20

        // Randomized run of exactly 256 ops from reset: op_count wraps to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), 1'b0);
        end
        check("op_count_wrap", op_count, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
